// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back job sequencer.
package wb_pkg;

  localparam int DEPTH_DEFAULT  = 61;
  localparam int WORDS_PER_PASS = 5 * DEPTH_DEFAULT;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    DRAIN,
    NEXT,
    DONE
  } wb_state_e;

  // Output words one filter pass produces for a row length of depth.
  function automatic int words_per_pass(input int depth);
    return 5 * depth;
  endfunction

endpackage

// File: rtl/wb_edge_det.sv
// Registered falling-edge detector; the history register only advances while en=1.
module wb_edge_det
  import wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else if (en) begin
      d_q <= d;
    end
  end

  assign fall = d_q & ~d;

endmodule

// File: rtl/wb_job_sequencer.sv
// Sequences write-back over a multi-pass conv job, one output channel at a time,
// and audits the number of output words produced per channel.
//
// state  | meaning
// IDLE   | waiting for a job request
// LAUNCH | pulse start_init; clear pass and word counters
// RUN    | count zero4 falling edges until the last pass is reached
// DRAIN  | last pass running; wait for end_op, then audit the word count
// NEXT   | advance to the next output channel or finish
// DONE   | one-cycle done pulse
module wb_job_sequencer
  import wb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int PASS_W = 8,
  parameter int OC_W   = 8,
  parameter int WCNT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [PASS_W-1:0] cfg_n_pass,
  input  logic [OC_W-1:0]   cfg_n_oc,
  input  logic              abort,
  input  logic              ext_stall,
  output logic              wb_stall,
  output logic              wb_start_init,
  output logic              wb_end_conv,
  input  logic              wb_zero4,
  input  logic              wb_end_op,
  input  logic              wb_p0_valid,
  input  logic              wb_p1_valid,
  output logic [OC_W-1:0]   oc_idx,
  output logic              busy,
  output logic              done,
  output logic              cnt_err
);

  localparam int WPP = words_per_pass(DEPTH);

  wb_state_e         state_q, state_d;
  logic [PASS_W-1:0] n_pass_q, n_pass_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [OC_W-1:0]   n_oc_q, n_oc_d;
  logic [OC_W-1:0]   oc_idx_q, oc_idx_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              cnt_err_q, cnt_err_d;

  logic              start_init_c, end_conv_c, done_c;
  logic              pass_end;
  logic              last_pass;
  logic [WCNT_W:0]   wsum;
  logic [WCNT_W-1:0] wcnt_sat;
  logic [31:0]       exp_words;

  wb_edge_det u_zero4_edge (
    .clk  (clk),
    .rst  (rst),
    .en   (~ext_stall),
    .d    (wb_zero4),
    .fall (pass_end)
  );

  assign wsum      = {1'b0, wcnt_q} + (WCNT_W+1)'(wb_p0_valid) + (WCNT_W+1)'(wb_p1_valid);
  assign wcnt_sat  = wsum[WCNT_W] ? '1 : wsum[WCNT_W-1:0];
  assign exp_words = 32'(n_pass_q) * 32'(WPP);
  assign last_pass = (pass_cnt_q == (n_pass_q - PASS_W'(1)));

  always_comb begin
    state_d      = state_q;
    n_pass_d     = n_pass_q;
    n_oc_d       = n_oc_q;
    oc_idx_d     = oc_idx_q;
    pass_cnt_d   = pass_cnt_q;
    wcnt_d       = wcnt_q;
    cnt_err_d    = cnt_err_q;
    start_init_c = 1'b0;
    end_conv_c   = 1'b0;
    done_c       = 1'b0;

    // abort bypasses the stall so a hung downstream can still be recovered
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else if (!ext_stall) begin
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            n_pass_d  = (cfg_n_pass == '0) ? PASS_W'(1) : cfg_n_pass;
            n_oc_d    = (cfg_n_oc == '0) ? OC_W'(1) : cfg_n_oc;
            oc_idx_d  = '0;
            cnt_err_d = 1'b0;
            state_d   = LAUNCH;
          end
        end
        LAUNCH: begin
          start_init_c = 1'b1;
          pass_cnt_d   = '0;
          wcnt_d       = '0;
          if (n_pass_q == PASS_W'(1)) begin
            end_conv_c = 1'b1;
            state_d    = DRAIN;
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          wcnt_d = wcnt_sat;
          if (last_pass) begin
            end_conv_c = 1'b1;
            state_d    = DRAIN;
          end else if (pass_end) begin
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
          end
        end
        DRAIN: begin
          wcnt_d = wcnt_sat;
          if (pass_end) begin
            cnt_err_d = 1'b1;
          end
          // words arriving alongside end_op still belong to this channel
          if (wb_end_op) begin
            if (32'(wcnt_sat) != exp_words) begin
              cnt_err_d = 1'b1;
            end
            state_d = NEXT;
          end
        end
        NEXT: begin
          if (oc_idx_q == (n_oc_q - OC_W'(1))) begin
            state_d = DONE;
          end else begin
            oc_idx_d = oc_idx_q + OC_W'(1);
            state_d  = LAUNCH;
          end
        end
        DONE: begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_pass_q   <= '0;
      n_oc_q     <= '0;
      oc_idx_q   <= '0;
      pass_cnt_q <= '0;
      wcnt_q     <= '0;
      cnt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_pass_q   <= n_pass_d;
      n_oc_q     <= n_oc_d;
      oc_idx_q   <= oc_idx_d;
      pass_cnt_q <= pass_cnt_d;
      wcnt_q     <= wcnt_d;
      cnt_err_q  <= cnt_err_d;
    end
  end

  assign cfg_ready     = (state_q == IDLE) && !ext_stall;
  assign busy          = (state_q != IDLE);
  assign wb_stall      = ext_stall;
  assign wb_start_init = start_init_c;
  assign wb_end_conv   = end_conv_c;
  assign done          = done_c;
  assign oc_idx        = oc_idx_q;
  assign cnt_err       = cnt_err_q;

endmodule

// File: tb/tb_wb_job_sequencer.sv
// Directed and randomized job runs against a timeline model of the write-back BFM.
module tb_wb_job_sequencer;

  localparam int WPP = 305;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready;
  logic [7:0] cfg_n_pass, cfg_n_oc;
  logic       abort, ext_stall, wb_stall;
  logic       wb_start_init, wb_end_conv;
  logic       wb_zero4, wb_end_op, wb_p0_valid, wb_p1_valid;
  logic [7:0] oc_idx;
  logic       busy, done, cnt_err;

  wb_job_sequencer #(.DEPTH(61), .PASS_W(8), .OC_W(8), .WCNT_W(20)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n_pass(cfg_n_pass), .cfg_n_oc(cfg_n_oc),
    .abort(abort), .ext_stall(ext_stall), .wb_stall(wb_stall),
    .wb_start_init(wb_start_init), .wb_end_conv(wb_end_conv),
    .wb_zero4(wb_zero4), .wb_end_op(wb_end_op),
    .wb_p0_valid(wb_p0_valid), .wb_p1_valid(wb_p1_valid),
    .oc_idx(oc_idx), .busy(busy), .done(done), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_si = -1, exp_ec = -1, exp_done = -1;
  int stall_at = -1, stall_len = 0;
  int act = 0;
  int si_seen = -1, ec_seen = -1;
  int la_g = 0, fa_g = 0;
  bit noise = 0;
  logic z_prev = 1'b0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // inputs are already applied; check combinational outputs, then cross one edge
  task automatic tick();
    #1;
    chk(32'(wb_stall), 32'(ext_stall), "wb_stall");
    chk(32'(wb_start_init), 32'(cyc == exp_si), "start_init");
    chk(32'(wb_end_conv), 32'(cyc == exp_ec), "end_conv");
    chk(32'(done), 32'(cyc == exp_done), "done");
    if (wb_start_init) si_seen = cyc;
    if (wb_end_conv) ec_seen = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // one BFM-active cycle, preceded by a frozen stall window when scheduled
  task automatic adv();
    logic p0s, p1s, eos;
    if (act == stall_at) begin
      p0s = wb_p0_valid; p1s = wb_p1_valid; eos = wb_end_op;
      wb_p0_valid = 0; wb_p1_valid = 0; wb_end_op = 0;
      wb_zero4 = z_prev;
      ext_stall = 1;
      for (int i = 0; i < stall_len; i++) begin
        if (exp_si >= cyc) exp_si++;
        if (exp_ec >= cyc) exp_ec++;
        if (exp_done >= cyc) exp_done++;
        tick();
      end
      ext_stall = 0;
      wb_p0_valid = p0s; wb_p1_valid = p1s; wb_end_op = eos;
    end
    if (noise) begin
      cfg_valid  = 1'($urandom_range(0, 1));
      cfg_n_pass = 8'($urandom);
      cfg_n_oc   = 8'($urandom);
    end
    tick();
    z_prev = wb_zero4;
    act++;
  endtask

  task automatic bfm_idle();
    wb_p0_valid = 0; wb_p1_valid = 0; wb_end_op = 0; wb_zero4 = 0;
    cfg_valid = 0; noise = 0;
    exp_si = -1; exp_ec = -1; exp_done = -1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(32'(busy), 32'd0, "idle_busy");
    end
  endtask

  // mode: 0 normal, 1 abort mid pass 1 of ch0, 2 abort with end_op of ch0,
  //       3 async reset mid last pass of last channel
  task automatic run_job(input int np_cfg, input int noc_cfg, input int drop_ch,
                         input int drop_n, input int mode, input bit nz);
    int np, noc, quota, half, w, r;
    bit exp_err;
    np  = (np_cfg == 0) ? 1 : np_cfg;
    noc = (noc_cfg == 0) ? 1 : noc_cfg;
    act = 0;
    exp_err = 0;
    cfg_valid  = 1;
    cfg_n_pass = np_cfg[7:0];
    cfg_n_oc   = noc_cfg[7:0];
    #1;
    chk(32'(cfg_ready), 32'd1, "ready_idle");
    chk(32'(busy), 32'd0, "busy_idle");
    exp_si = cyc + 1;
    if (np == 1) exp_ec = exp_si;
    tick();
    cfg_valid = 0;
    noise = nz;
    chk(32'(cnt_err), 32'd0, "err_clr_on_accept");
    chk(32'(busy), 32'd1, "busy_after_accept");
    chk(32'(cfg_ready), 32'd0, "ready_busy");
    for (int ch = 0; ch < noc; ch++) begin
      la_g = act;
      adv();
      chk(32'(oc_idx), 32'(ch), "oc_idx");
      for (int p = 0; p < np; p++) begin
        quota = WPP;
        if (ch == drop_ch && p == np - 1) begin
          quota = WPP - drop_n;
          if (drop_n != 0) exp_err = 1;
        end
        half = quota / 2;
        while (quota > 0) begin
          w = $urandom_range(0, 2);
          if (w > quota) w = quota;
          r = $urandom_range(0, 1);
          wb_p0_valid = (w == 2) || (w == 1 && r == 1);
          wb_p1_valid = (w == 2) || (w == 1 && r == 0);
          wb_zero4 = (p < np - 1);
          adv();
          quota -= w;
          if (mode == 1 && ch == 0 && p == 1 && quota <= half) begin
            bfm_idle();
            abort = 1;
            tick();
            abort = 0;
            chk(32'(busy), 32'd0, "abort_busy");
            chk(32'(cfg_ready), 32'd1, "abort_ready");
            idle_ticks(3);
            return;
          end
          if (mode == 3 && ch == noc - 1 && p == np - 1 && quota <= half) begin
            bfm_idle();
            #2;
            rst = 1;
            #1;
            chk(32'(cfg_ready), 32'd1, "rst_ready");
            chk(32'(busy), 32'd0, "rst_busy");
            chk(32'(oc_idx), 32'd0, "rst_oc_idx");
            chk(32'(cnt_err), 32'd0, "rst_cnt_err");
            chk(32'(wb_start_init | wb_end_conv | done), 32'd0, "rst_pulses");
            @(posedge clk);
            #1;
            cyc++;
            rst = 0;
            idle_ticks(3);
            return;
          end
        end
        wb_p0_valid = 0; wb_p1_valid = 0;
        if (p < np - 1) begin
          wb_zero4 = 0;
          if (p == np - 2) begin
            exp_ec = cyc + 1;
            fa_g = act;
          end
          adv();
        end
      end
      wb_end_op = 1;
      if (mode == 2 && ch == 0) begin
        abort = 1;
        exp_si = -1; exp_ec = -1; exp_done = -1;
        noise = 0; cfg_valid = 0;
        tick();
        abort = 0;
        bfm_idle();
        chk(32'(busy), 32'd0, "abort_eop_busy");
        chk(32'(cfg_ready), 32'd1, "abort_eop_ready");
        chk(32'(cnt_err), 32'd0, "abort_eop_no_audit");
        idle_ticks(3);
        return;
      end
      if (ch == noc - 1) exp_done = cyc + 2;
      else begin
        exp_si = cyc + 2;
        if (np == 1) exp_ec = cyc + 2;
      end
      adv();
      wb_end_op = 0;
      chk(32'(cnt_err), 32'(exp_err), "cnt_err_at_end_op");
      adv();
    end
    adv();
    noise = 0;
    cfg_valid = 0;
    tick();
    chk(32'(cfg_ready), 32'd1, "ready_after_done");
    chk(32'(busy), 32'd0, "busy_after_done");
    chk(32'(cnt_err), 32'(exp_err), "cnt_err_final");
    bfm_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np_r, noc_r, dch, dn;
    rst = 1; abort = 0; ext_stall = 0;
    cfg_n_pass = 0; cfg_n_oc = 0;
    bfm_idle();
    #3;
    chk(32'(cfg_ready), 32'd1, "reset_ready");
    chk(32'(busy), 32'd0, "reset_busy");
    chk(32'(wb_start_init | wb_end_conv | done | cnt_err), 32'd0, "reset_outputs");
    chk(32'(oc_idx), 32'd0, "reset_oc_idx");
    @(posedge clk);
    #1;
    rst = 0;
    cyc = 0;
    idle_ticks(2);

    run_job(1, 1, -1, 0, 0, 0);
    run_job(3, 2, -1, 0, 0, 0);

    stall_at = 40; stall_len = 10;
    run_job(3, 1, -1, 0, 0, 0);
    chk(32'(ec_seen - si_seen), 32'(fa_g - la_g + 1 + 10), "end_conv_slip");
    stall_at = -1; stall_len = 0;

    run_job(2, 2, 1, 1, 0, 0);
    chk(32'(cnt_err), 32'd1, "cnt_err_sticky");
    run_job(1, 1, -1, 0, 0, 0);

    run_job(3, 1, -1, 0, 1, 0);
    run_job(1, 1, 0, 5, 2, 0);

    run_job(0, 0, -1, 0, 0, 1);
    run_job(1, 2, -1, 0, 3, 0);

    for (int k = 0; k < 4; k++) begin
      np_r  = $urandom_range(0, 3);
      noc_r = $urandom_range(0, 2);
      dch = -1; dn = 0;
      if ($urandom_range(0, 1) == 1) begin
        dch = $urandom_range(0, (noc_r == 0) ? 0 : noc_r - 1);
        dn  = $urandom_range(1, 3);
      end
      run_job(np_r, noc_r, dch, dn, 0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
